// File: rtl/mult_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : mult_writeback
//  Purpose  : Buffers 128-bit multiplier products in a small FIFO and streams
//             each one to the register file as two 64-bit writes (low, high).
//  Revision : 1.0  initial release
// ============================================================================
module mult_writeback #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [127:0]             in_product,
    input  logic                     in_overflow,
    input  logic [4:0]               in_rd,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [63:0]              wb_data,
    output logic [4:0]               wb_rd,
    output logic                     wb_half,
    output logic                     ovf_sticky,
    input  logic                     ovf_clear,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } state_t;

    logic [127:0]     r_prod_mem [DEPTH];
    logic             r_ovf_mem  [DEPTH];
    logic [4:0]       r_rd_mem   [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;
    logic             r_ovf_sticky;

    logic             w_push;
    logic             w_xfer;
    logic             w_pop;

    // Handshakes depend only on registered occupancy: no in->wb bypass.
    assign in_ready   = (r_count < CNT_W'(DEPTH));
    assign wb_valid   = (r_count != '0);
    assign count      = r_count;
    assign ovf_sticky = r_ovf_sticky;

    assign w_push = in_valid && in_ready;
    assign w_xfer = wb_valid && wb_ready;
    assign w_pop  = w_xfer && (r_state == ST_HI);

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_prod_mem[r_wptr] <= in_product;
            r_ovf_mem[r_wptr]  <= in_overflow;
            r_rd_mem[r_wptr]   <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Half-select FSM: the high word transfer retires the head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LO;
        end else begin
            case (r_state)
                ST_LO:   if (w_xfer) r_state <= ST_HI;
                ST_HI:   if (w_xfer) r_state <= ST_LO;
                default: r_state <= ST_LO;
            endcase
        end
    end

    // A set on the retiring high word takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_pop && r_ovf_mem[r_rptr]) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    always_comb begin
        wb_data = '0;
        wb_rd   = '0;
        wb_half = 1'b0;
        if (wb_valid) begin
            if (r_state == ST_HI) begin
                wb_data = r_prod_mem[r_rptr][127:64];
                wb_rd   = r_rd_mem[r_rptr] + 5'd1;
                wb_half = 1'b1;
            end else begin
                wb_data = r_prod_mem[r_rptr][63:0];
                wb_rd   = r_rd_mem[r_rptr];
                wb_half = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_writeback
//  Purpose  : Randomized and directed scoreboard bench for mult_writeback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_writeback;

    localparam int DEPTH = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [127:0]           in_product;
    logic                   in_overflow;
    logic [4:0]             in_rd;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [63:0]            wb_data;
    logic [4:0]             wb_rd;
    logic                   wb_half;
    logic                   ovf_sticky;
    logic                   ovf_clear;
    logic [$clog2(DEPTH):0] count;

    mult_writeback #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_overflow(in_overflow),
        .in_rd      (in_rd),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_half    (wb_half),
        .ovf_sticky (ovf_sticky),
        .ovf_clear  (ovf_clear),
        .count      (count)
    );

    // One expected register-file write; vis is the first cycle it may appear.
    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        half;
        logic        ovf;
        int          vis;
    } word_t;

    word_t exp_q[$];
    logic  sticky_m;
    int    cyc;
    int    n_tests;
    int    n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; accepted pushes enter the scoreboard as two words.
    task automatic cyc_drive(input logic v, input logic [127:0] p, input logic o,
                             input logic [4:0] r, input logic wr, input logic clr);
        word_t w;
        in_valid    = v;
        in_product  = p;
        in_overflow = o;
        in_rd       = r;
        wb_ready    = wr;
        ovf_clear   = clr;
        if (v && ((exp_q.size() + 1) / 2) < DEPTH) begin
            w.data = p[63:0];   w.rd = r;         w.half = 1'b0; w.ovf = 1'b0; w.vis = cyc + 1;
            exp_q.push_back(w);
            w.data = p[127:64]; w.rd = r + 5'd1;  w.half = 1'b1; w.ovf = o;    w.vis = cyc + 1;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        end
        chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares presented outputs with the scoreboard head each cycle.
    int    nv;
    int    ent;
    word_t mw;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_wb_valid", 128'(wb_valid), 128'd0);
                chk("rst_in_ready", 128'(in_ready), 128'd1);
                chk("rst_count", 128'(count), 128'd0);
                chk("rst_wb_data", 128'(wb_data), 128'd0);
                chk("rst_sticky", 128'(ovf_sticky), 128'd0);
            end else begin
                nv = 0;
                foreach (exp_q[i]) if (exp_q[i].vis <= cyc) nv++;
                ent = (nv + 1) / 2;
                chk("wb_valid", 128'(wb_valid), 128'(nv != 0));
                chk("count", 128'(count), 128'(ent));
                chk("in_ready", 128'(in_ready), 128'(ent < DEPTH));
                chk("ovf_sticky", 128'(ovf_sticky), 128'(sticky_m));
                if (nv != 0) begin
                    chk("wb_data", 128'(wb_data), 128'(exp_q[0].data));
                    chk("wb_rd", 128'(wb_rd), 128'(exp_q[0].rd));
                    chk("wb_half", 128'(wb_half), 128'(exp_q[0].half));
                    if (wb_ready) begin
                        mw = exp_q.pop_front();
                        if (mw.half && mw.ovf) sticky_m = 1'b1;
                        else if (ovf_clear)    sticky_m = 1'b0;
                    end else if (ovf_clear) begin
                        sticky_m = 1'b0;
                    end
                end else begin
                    chk("idle_wb_data", 128'(wb_data), 128'd0);
                    chk("idle_wb_rd", 128'(wb_rd), 128'd0);
                    chk("idle_wb_half", 128'(wb_half), 128'd0);
                    if (ovf_clear) sticky_m = 1'b0;
                end
            end
        end
    end

    logic [127:0] p;
    initial begin
        n_tests     = 0;
        n_fail      = 0;
        sticky_m    = 1'b0;
        in_valid    = 1'b0;
        in_product  = '0;
        in_overflow = 1'b0;
        in_rd       = '0;
        wb_ready    = 1'b0;
        ovf_clear   = 1'b0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single product, low then high word, then idle
        cyc_drive(1'b1, 128'h1D8E, 1'b0, 5'd4, 1'b1, 1'b0);
        chk("t031_lo_data", 128'(wb_data), 128'h1D8E);
        chk("t031_lo_rd", 128'(wb_rd), 128'd4);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("t031_hi_data", 128'(wb_data), 128'd0);
        chk("t031_hi_rd", 128'(wb_rd), 128'd5);
        chk("t031_hi_half", 128'(wb_half), 128'd1);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("t031_done", 128'(wb_valid), 128'd0);

        // Negative product, destination index wraps 31 -> 0
        p = -128'sd2944665;
        cyc_drive(1'b1, p, 1'b0, 5'd31, 1'b1, 1'b0);
        chk("t032_lo_data", 128'(wb_data), 128'hFFFFFFFFFFD31167);
        chk("t032_lo_rd", 128'(wb_rd), 128'd31);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("t032_hi_data", 128'(wb_data), 128'hFFFFFFFFFFFFFFFF);
        chk("t032_hi_rd", 128'(wb_rd), 128'd0);
        drain();

        // Backpressure: third push refused while full
        cyc_drive(1'b1, rnd128(), 1'b0, 5'd1, 1'b0, 1'b0);
        cyc_drive(1'b1, rnd128(), 1'b0, 5'd2, 1'b0, 1'b0);
        cyc_drive(1'b1, rnd128(), 1'b0, 5'd3, 1'b0, 1'b0);
        chk("t033_count", 128'(count), 128'd2);
        chk("t033_in_ready", 128'(in_ready), 128'd0);
        drain();

        // Full FIFO with continuous traffic on both sides
        cyc_drive(1'b1, rnd128(), 1'b0, 5'($urandom), 1'b0, 1'b0);
        cyc_drive(1'b1, rnd128(), 1'b0, 5'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc_drive(1'b1, rnd128(), 1'b0, 5'($urandom), 1'b1, 1'b0);
        end
        drain();

        // Sticky overflow: set beats clear on the high word, then clears
        cyc_drive(1'b1, rnd128(), 1'b1, 5'd7, 1'b1, 1'b1);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b1);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("t035_set", 128'(ovf_sticky), 128'd1);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("t035_clear", 128'(ovf_sticky), 128'd0);

        // Asynchronous reset while presenting a high word with two entries
        cyc_drive(1'b1, rnd128(), 1'b0, 5'd9, 1'b0, 1'b0);
        cyc_drive(1'b1, rnd128(), 1'b0, 5'd10, 1'b0, 1'b0);
        cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("t036_pre_half", 128'(wb_half), 128'd1);
        chk("t036_pre_count", 128'(count), 128'd2);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        sticky_m = 1'b0;
        #1;
        chk("t036_wb_valid", 128'(wb_valid), 128'd0);
        chk("t036_count", 128'(count), 128'd0);
        chk("t036_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc_drive(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        end

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            cyc_drive(1'($urandom_range(0, 1)), rnd128(), 1'($urandom_range(0, 1)),
                      5'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_writeback.md
MULT_WRITEBACK -- requirements
Module: mult_writeback

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 2, giving the FIFO entry count (power of two, ≥2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  input  1  multiplier result offered.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_product  input  128  signed 128-bit product from multiplier.
REQ-007 in_overflow  input  1  multiplier overflow flag for this product.
REQ-008 in_rd  input  5  destination register index for low half.
REQ-009 wb_valid  output  1  writeback word valid.
REQ-010 wb_ready  input  1  register file accepts writeback word.
REQ-011 wb_data  output  64  writeback word.
REQ-012 wb_rd  output  5  writeback register index.
REQ-013 wb_half  output  1  0 = low word, 1 = high word.
REQ-014 ovf_sticky  output  1  sticky overflow status.
REQ-015 ovf_clear  input  1  synchronous clear of ovf_sticky.
REQ-016 count  output  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Storage SHALL be a DEPTH-entry FIFO of {product[127:0], overflow, rd[4:0]} with wrapping read/write pointers.
REQ-018 in_ready SHALL equal (count < DEPTH), from registered state only; no bypass, so a push is refused when full even if a pop occurs that cycle.
REQ-019 Push SHALL occur on the rising edge with in_valid && in_ready; pop SHALL occur on the high-word transfer (REQ-023).
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 wb_valid SHALL equal (count != 0); no combinational path from in_* to wb_*; minimum latency from push edge to wb_valid = 1 cycle.
REQ-022 Output FSM states: LO (present head product[63:0], wb_half=0, wb_rd=head.rd) and HI (present head product[127:64], wb_half=1, wb_rd=(head.rd+1) mod 32).
REQ-023 Transfer = wb_valid && wb_ready; LO→HI on transfer; HI→LO on transfer with head pop; no transfer → state and outputs held stable.
REQ-024 When wb_valid=0, wb_data, wb_rd and wb_half SHALL be 0, and the FSM SHALL be in LO.
REQ-025 ovf_sticky SHALL be set on the HI transfer of an entry whose overflow=1; ovf_clear clears it; simultaneous set and clear SHALL result in set.
REQ-026 Product halves SHALL be passed bit-exact; no sign extension or modification.
REQ-027 in_product/in_overflow/in_rd are sampled only on push; values while in_valid=0 or in_ready=0 SHALL be ignored.

Reset
REQ-028 While rst_n=0: pointers=0, count=0, FSM=LO, ovf_sticky=0, wb_valid=0, wb_data=0, wb_rd=0, wb_half=0, in_ready=1.
REQ-029 Assertion of rst_n mid-operation (including in HI) SHALL discard all entries immediately, without waiting for a clock edge.
REQ-030 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 Push product=7566 (0x1D8E), rd=4, wb_ready=1 -> cycle+1: wb_data=0x0000000000001D8E, rd=4, half=0; cycle+2: wb_data=0, rd=5, half=1; then wb_valid=0.
REQ-032 Push product=-2944665, rd=31 -> low word 0xFFFFFFFFFFD31167 to rd=31, then high word 0xFFFFFFFFFFFFFFFF to rd=0 (wrap).
REQ-033 wb_ready=0, push 3 products -> first two accepted, count=2, in_ready=0, third refused; raise wb_ready -> words in order L0,H0,L1,H1.
REQ-034 Full FIFO with wb_ready=1 and in_valid=1 held -> push accepted only the cycle after the HI pop; count never exceeds 2.
REQ-035 Push overflow=1 entry with ovf_clear=1 asserted during its HI transfer -> ovf_sticky=1; next cycle ovf_clear=1 -> ovf_sticky=0.
REQ-036 Assert rst_n=0 while in HI with count=2 -> asynchronously wb_valid=0, count=0, in_ready=1; no further words after release.
